// File: rtl/traffic_ctrl_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_gen_if
// Brief    : Signal bundle between the input synchronisers / LED drivers and
//            the traffic_ctrl_gen intersection controller. The Night input
//            exists only when FLASH_MODE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface traffic_ctrl_gen_if #(
    parameter int CNT_W = 8
);
    logic             Sensor;
    logic             WalkReq;
    logic             Reprogram;
`ifdef FLASH_MODE_EN
    logic             Night;
`endif
    logic [6:0]       LEDs;
    logic [2:0]       State;
    logic             Walk_Pending;
    logic [CNT_W-1:0] Time_Left;

`ifdef FLASH_MODE_EN
    // Stimulus side: drives the synchronised requests, observes the lights
    modport master (
        output Sensor, WalkReq, Reprogram, Night,
        input  LEDs, State, Walk_Pending, Time_Left
    );

    // Controller side
    modport slave (
        input  Sensor, WalkReq, Reprogram, Night,
        output LEDs, State, Walk_Pending, Time_Left
    );
`else
    // Stimulus side: drives the synchronised requests, observes the lights
    modport master (
        output Sensor, WalkReq, Reprogram,
        input  LEDs, State, Walk_Pending, Time_Left
    );

    // Controller side
    modport slave (
        input  Sensor, WalkReq, Reprogram,
        output LEDs, State, Walk_Pending, Time_Left
    );
`endif
endinterface
`default_nettype wire

// File: rtl/traffic_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_gen
// Brief    : Main/side intersection controller with pedestrian walk phase,
//            internal tick prescaler, per-phase countdown, sensor-driven
//            green extension and synchronous reprogram restart.
//            Optional macro FLASH_MODE_EN adds the Night input and the
//            flashing-yellow state (code 7).
// Revision : 1.0 - initial release
// ============================================================================
module traffic_ctrl_gen #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 1000,
    parameter int T_BASE   = 6,
    parameter int T_EXT    = 3,
    parameter int T_YEL    = 2,
    parameter int T_WALK   = 3
) (
    input  logic             clk,
    input  logic             Reset_n,
    traffic_ctrl_gen_if.slave bus
);

    // Zero-valued parameters behave as 1; reload values are length-1 in CNT_W bits
    localparam int c_TICK_DIV = (TICK_DIV < 1) ? 1 : TICK_DIV;
    localparam int c_PW       = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam logic [c_PW-1:0]  c_PMAX     = c_PW'(c_TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_RLD_BASE = CNT_W'(((T_BASE < 1) ? 1 : T_BASE) - 1);
    localparam logic [CNT_W-1:0] c_RLD_EXT  = CNT_W'(((T_EXT  < 1) ? 1 : T_EXT)  - 1);
    localparam logic [CNT_W-1:0] c_RLD_YEL  = CNT_W'(((T_YEL  < 1) ? 1 : T_YEL)  - 1);
    localparam logic [CNT_W-1:0] c_RLD_WALK = CNT_W'(((T_WALK < 1) ? 1 : T_WALK) - 1);

    // LED patterns {Rm,Ym,Gm,Rs,Ys,Gs,Walk}
    localparam logic [6:0] c_LED_GM   = 7'b0011000;
    localparam logic [6:0] c_LED_YM   = 7'b0101000;
    localparam logic [6:0] c_LED_WALK = 7'b1001001;
    localparam logic [6:0] c_LED_GS   = 7'b1000010;
    localparam logic [6:0] c_LED_YS   = 7'b1000100;
    localparam logic [6:0] c_LED_RED  = 7'b1001000;
    localparam logic [6:0] c_LED_FLA  = 7'b0101000;
    localparam logic [6:0] c_LED_FLB  = 7'b0001000;

    typedef enum logic [2:0] {
        S_GM1   = 3'd0,
        S_GM2   = 3'd1,
        S_YM    = 3'd2,
        S_WALK  = 3'd3,
        S_GS    = 3'd4,
        S_GSX   = 3'd5,
        S_YS    = 3'd6,
`ifdef FLASH_MODE_EN
        S_FLASH = 3'd7
`else
        S_RSVD  = 3'd7
`endif
    } state_t;

    state_t           r_state;
    logic [6:0]       r_leds;
    logic             r_walk_pending;
    logic [CNT_W-1:0] r_time_left;
    logic [c_PW-1:0]  r_presc;
`ifdef FLASH_MODE_EN
    logic             r_flash_phase;
    logic             w_flash_nxt;
`endif

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_tl_nxt;
    logic [c_PW-1:0]  w_presc_nxt;
    logic             w_tick;
    logic             w_expire;
    logic             w_enter_walk;
    logic             w_wp_nxt;

    // Steady-state LED pattern for each phase
    function automatic logic [6:0] led_of(input state_t s);
        logic [6:0] v;
        case (s)
            S_GM1, S_GM2: v = c_LED_GM;
            S_YM:         v = c_LED_YM;
            S_WALK:       v = c_LED_WALK;
            S_GS, S_GSX:  v = c_LED_GS;
            S_YS:         v = c_LED_YS;
            default:      v = c_LED_RED;
        endcase
        return v;
    endfunction

    // Next-state, countdown/prescaler reload and walk-latch logic
    always_comb begin
        w_tick      = (r_presc == c_PMAX);
        w_expire    = w_tick && (r_time_left == '0);
        w_state_nxt = r_state;
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        // Saturating decrement keeps the counter parked at 0 in phases without expiry
        w_tl_nxt    = (w_tick && (r_time_left != '0)) ? r_time_left - 1'b1 : r_time_left;
`ifdef FLASH_MODE_EN
        w_flash_nxt = r_flash_phase;
`endif

        if (bus.Reprogram) begin
            w_state_nxt = S_GM1;
            w_presc_nxt = '0;
            w_tl_nxt    = c_RLD_BASE;
        end
`ifdef FLASH_MODE_EN
        else if (bus.Night) begin
            if (r_state != S_FLASH) begin
                w_state_nxt = S_FLASH;
                w_presc_nxt = '0;
                w_tl_nxt    = '0;
                w_flash_nxt = 1'b0;
            end else if (w_tick) begin
                w_flash_nxt = ~r_flash_phase;
            end
        end
        else if (r_state == S_FLASH) begin
            w_state_nxt = S_GM1;
            w_presc_nxt = '0;
            w_tl_nxt    = c_RLD_BASE;
        end
`else
        else if (r_state == S_RSVD) begin
            w_state_nxt = S_GM1;
            w_presc_nxt = '0;
            w_tl_nxt    = c_RLD_BASE;
        end
`endif
        else if (w_expire) begin
            w_presc_nxt = '0;
            case (r_state)
                S_GM1: begin
                    w_state_nxt = S_GM2;
                    w_tl_nxt    = bus.Sensor ? c_RLD_EXT : c_RLD_BASE;
                end
                S_GM2: begin
                    w_state_nxt = S_YM;
                    w_tl_nxt    = c_RLD_YEL;
                end
                S_YM: begin
                    w_state_nxt = r_walk_pending ? S_WALK : S_GS;
                    w_tl_nxt    = r_walk_pending ? c_RLD_WALK : c_RLD_BASE;
                end
                S_WALK: begin
                    w_state_nxt = S_GS;
                    w_tl_nxt    = c_RLD_BASE;
                end
                S_GS: begin
                    w_state_nxt = bus.Sensor ? S_GSX : S_YS;
                    w_tl_nxt    = bus.Sensor ? c_RLD_EXT : c_RLD_YEL;
                end
                S_GSX: begin
                    w_state_nxt = S_YS;
                    w_tl_nxt    = c_RLD_YEL;
                end
                default: begin
                    w_state_nxt = S_GM1;
                    w_tl_nxt    = c_RLD_BASE;
                end
            endcase
        end

        // Entering the walk phase serves the request; a coincident new request re-arms it
        w_enter_walk = (w_state_nxt == S_WALK) && (r_state != S_WALK);
        w_wp_nxt     = bus.Reprogram ? 1'b0 :
                       ((r_walk_pending & ~w_enter_walk) | (bus.WalkReq & (r_state != S_WALK)));
    end

    // State, registered LEDs, countdown, prescaler and walk latch
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= S_GM1;
            r_leds         <= c_LED_GM;
            r_walk_pending <= 1'b0;
            r_time_left    <= c_RLD_BASE;
            r_presc        <= '0;
`ifdef FLASH_MODE_EN
            r_flash_phase  <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_walk_pending <= w_wp_nxt;
            r_time_left    <= w_tl_nxt;
            r_presc        <= w_presc_nxt;
`ifdef FLASH_MODE_EN
            r_flash_phase  <= w_flash_nxt;
            r_leds         <= (w_state_nxt == S_FLASH) ? (w_flash_nxt ? c_LED_FLB : c_LED_FLA)
                                                       : led_of(w_state_nxt);
`else
            r_leds         <= led_of(w_state_nxt);
`endif
        end
    end

    assign bus.LEDs         = r_leds;
    assign bus.State        = r_state;
    assign bus.Walk_Pending = r_walk_pending;
    assign bus.Time_Left    = r_time_left;

endmodule
`default_nettype wire
